// File: rtl/dadda_mul_pipe_if.sv
// Operand/result stream bundle for dadda_mul_pipe: valid/ready in, valid/ready out.
// slave is the multiplier side, master is the producer/consumer side.
interface dadda_mul_pipe_if #(
    parameter int WIDTH = 6,
    parameter int TAG_W = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 is_signed;
    logic [TAG_W-1:0]     in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_p;
    logic [TAG_W-1:0]     out_tag;

    modport slave (
        input  in_valid, a, b, is_signed, in_tag, out_ready,
        output in_ready, out_valid, out_p, out_tag
    );

    modport master (
        output in_valid, a, b, is_signed, in_tag, out_ready,
        input  in_ready, out_valid, out_p, out_tag
    );
endinterface

// File: rtl/dadda_mul_pipe.sv
// WIDTH x WIDTH signed/unsigned Dadda multiplier, 3 register stages (PP, tree, CPA), 1 op/cycle.
// Backpressure ripples combinationally from out_ready; empty stages still fill, up to 3 ops held.
module dadda_mul_pipe #(
    parameter int WIDTH = 6,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    dadda_mul_pipe_if.slave    io_mul
);
    localparam int PW   = 2 * WIDTH;
    localparam int HMAX = WIDTH + 2;

    typedef logic [HMAX-1:0] col_t;

    logic                 r_v1, r_v2, r_v3;
    logic [WIDTH-1:0]     r_pp [WIDTH];
    logic                 r_sgn1;
    logic [TAG_W-1:0]     r_tag1, r_tag2, r_tag3;
    logic [PW-1:0]        r_row0, r_row1;
    logic [PW-1:0]        r_p;

    logic                 w_ld1, w_ld2, w_ld3;
    logic [WIDTH-1:0]     w_pp [WIDTH];
    logic [PW-1:0]        w_row0, w_row1;

    function automatic int dseq(input int s);
        case (s)
            0:       return 28;
            1:       return 19;
            2:       return 13;
            3:       return 9;
            4:       return 6;
            5:       return 4;
            6:       return 3;
            default: return 2;
        endcase
    endfunction

    assign w_ld3 = !r_v3 || io_mul.out_ready;
    assign w_ld2 = !r_v2 || w_ld3;
    assign w_ld1 = !r_v1 || w_ld2;

    assign io_mul.in_ready  = w_ld1;
    assign io_mul.out_valid = r_v3;
    assign io_mul.out_p     = r_p;
    assign io_mul.out_tag   = r_tag3;

    // Baugh-Wooley: cross terms involving exactly one sign bit are inverted in signed mode
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                w_pp[i][j] = io_mul.a[i] & io_mul.b[j];
                if (io_mul.is_signed && ((i == WIDTH-1) != (j == WIDTH-1)))
                    w_pp[i][j] = ~w_pp[i][j];
            end
        end
    end

    always_comb begin
        col_t       cur [PW];
        col_t       nxt [PW];
        int         h   [PW];
        int         nh  [PW];
        int         ptr, tot, d;
        logic [1:0] fa;

        for (int c = 0; c < PW; c++) begin
            cur[c] = '0;
            h[c]   = 0;
            nxt[c] = '0;
            nh[c]  = 0;
        end
        ptr = 0;
        tot = 0;
        d   = 2;
        fa  = '0;

        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                cur[i+j][h[i+j]] = r_pp[i][j];
                h[i+j]++;
            end
        end
        // Baugh-Wooley correction constants ride in the tree as ordinary bits
        cur[WIDTH][h[WIDTH]] = r_sgn1;
        h[WIDTH]++;
        cur[PW-1][h[PW-1]] = r_sgn1;
        h[PW-1]++;

        for (int s = 0; s < 8; s++) begin
            d = dseq(s);
            for (int c = 0; c < PW; c++) begin
                nxt[c] = '0;
                nh[c]  = 0;
            end
            for (int c = 0; c < PW; c++) begin
                ptr = 0;
                tot = h[c] + nh[c];
                for (int k = 0; k < HMAX; k++) begin
                    if (tot > d) begin
                        if (tot - d >= 2) begin
                            fa = {1'b0, cur[c][ptr]} + {1'b0, cur[c][ptr+1]} + {1'b0, cur[c][ptr+2]};
                            ptr = ptr + 3;
                            tot = tot - 2;
                        end else begin
                            fa = {1'b0, cur[c][ptr]} + {1'b0, cur[c][ptr+1]};
                            ptr = ptr + 2;
                            tot = tot - 1;
                        end
                        nxt[c][nh[c]] = fa[0];
                        nh[c]++;
                        if (c < PW - 1) begin
                            nxt[c+1][nh[c+1]] = fa[1];
                            nh[c+1]++;
                        end
                    end
                end
                for (int k = 0; k < HMAX; k++) begin
                    if (k >= ptr && k < h[c]) begin
                        nxt[c][nh[c]] = cur[c][k];
                        nh[c]++;
                    end
                end
            end
            cur = nxt;
            h   = nh;
        end

        for (int c = 0; c < PW; c++) begin
            w_row0[c] = cur[c][0];
            w_row1[c] = cur[c][1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_v3   <= 1'b0;
            r_p    <= '0;
            r_tag3 <= '0;
        end else begin
            if (w_ld1) r_v1 <= io_mul.in_valid;
            if (w_ld2) r_v2 <= r_v1;
            if (w_ld3) begin
                r_v3 <= r_v2;
                if (r_v2) begin
                    r_p    <= r_row0 + r_row1;
                    r_tag3 <= r_tag2;
                end
            end
        end
    end

    // Payload registers need no reset: the valid bits gate everything they feed
    always_ff @(posedge clk) begin
        if (w_ld1 && io_mul.in_valid) begin
            r_pp   <= w_pp;
            r_sgn1 <= io_mul.is_signed;
            r_tag1 <= io_mul.in_tag;
        end
        if (w_ld2 && r_v1) begin
            r_row0 <= w_row0;
            r_row1 <= w_row1;
            r_tag2 <= r_tag1;
        end
    end
endmodule

// File: doc/dadda_mul_pipe.md
Name: dadda_mul_pipe

Overview:
Parametrised, pipelined successor to the 6x6 Dadda tree multiplier. It multiplies two WIDTH-bit operands in either unsigned or two's-complement signed mode, with the mode selected per transaction. The datapath is split into three register stages: partial products, Dadda reduction to two rows, and final carry-propagate add. A valid/ready handshake on both sides provides full-throughput streaming and backpressure, for use inside datapath and MAC blocks.

Parameters:
WIDTH, 6, operand width in bits (legal range 4..16); product width is 2*WIDTH.
TAG_W, 4, width of the user tag carried alongside each operation, unmodified.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  synchronous, active-low reset.
in_valid  input  1  operand set present on a, b, is_signed, in_tag.
in_ready  output  1  block can accept an operand set this cycle.
a  input  WIDTH  multiplicand.
b  input  WIDTH  multiplier.
is_signed  input  1  1 = both operands two's complement; 0 = both unsigned.
in_tag  input  TAG_W  user tag, returned with the result.
out_valid  output  1  out_p and out_tag hold a valid result.
out_ready  input  1  downstream accepts the result this cycle.
out_p  output  2*WIDTH  product (signed or unsigned per the op's is_signed).
out_tag  output  TAG_W  tag of the op in out_p.

Behaviour:
- Reset (rst_n=0 at a rising edge): all stage valid bits cleared; out_valid=0, out_p=0, out_tag=0. in_ready=1 from the first cycle after reset. Ops in flight when reset is asserted are discarded, and no partial result appears.
- Stage S1 (partial products): register WIDTH x WIDTH AND array a[i]&b[j]. Signed mode uses Baugh-Wooley: invert the PP bits where exactly one index equals WIDTH-1, and add constant 1 at columns WIDTH and 2*WIDTH-1. Register tag.
- Stage S2 (Dadda tree): reduce the columns using the Dadda height sequence 2,3,4,6,9,13,... down to 2 rows using full and half adders. Register the two rows and the tag.
- Stage S3 (final adder): 2*WIDTH-bit CPA; carry out of the MSB is discarded. Register into out_p/out_tag; out_valid = S3 valid.
- Each stage k holds a valid bit v_k. Stage k loads when !v_k or stage k+1 advances; S3 advances when !out_valid or out_ready.
- in_ready = (!v1 or S1 advances). This is combinational from out_ready through the stage chain; there is no skid buffer.
- Transfer occurs only when valid&ready are both 1 at a rising edge, on both sides.
- Latency: if an op is accepted at edge k with no stall, out_valid=1 with its result after edge k+2 (3 register stages). Throughput is 1 op/cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0, out_p/out_tag are held stable. Bubbles (v_k=0) upstream still collapse, so at most 3 ops are buffered. in_ready falls only when v1=v2=v3=1 and out_ready=0.
- Ordering: results leave strictly in acceptance order, and each tag stays paired with its own product.
- is_signed is latched per op in S1 and applies to that op only; mixed-mode back-to-back ops are legal.
- Arithmetic is exact for all operand pairs. Signed max magnitude is (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2), which fits in 2*WIDTH bits; the unsigned max (2^WIDTH-1)^2 also fits. No overflow flag is needed.
- Inputs are ignored (no state change) when in_valid=0 or in_ready=0.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, out_p=0, out_tag=0 throughout. After release, in_ready=1 and a fresh op emerges after 3 edges.
- Unsigned corners, WIDTH=6: a=63,b=63,tag=3 -> out_p=3969 (0xF81), tag 3. a=0,b=45 -> 0. a=1,b=63 -> 63. Each appears exactly 3 edges after acceptance.
- Signed corners, WIDTH=6: (-32)*(-32)=1024 (0x400); (-32)*31=-992 (0xC20); (-1)*(-1)=1; 31*(-1)=-31 (0xFE1). Interleave with unsigned ops each cycle -> every result matches its own mode and tag.
- Backpressure: stream tags 0..7 with out_ready=0 from cycle 2 for 5 cycles -> in_ready drops after 3 ops are buffered and out_p/out_tag stay stable. On release, tags 0..7 arrive in order with no loss or duplication.
- Reset mid-stream: assert rst_n=0 with 3 ops in flight -> no result is ever emitted for them. The first post-reset op's tag is the next output seen.
- Parameter sweep: WIDTH=4,8,16, TAG_W=1 -> exhaustive (4,8) or 10k random (16) signed/unsigned pairs with random out_ready match the reference model bit-exact.
